// File: rtl/ram_1r1w_mask_sync.sv
// 1R1W single-clock memory with registered read port, per-lane write mask,
// per-entry valid tracking with reset/flush clearing and optional write-to-read bypass.
module ram_1r1w_mask_sync #(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned WIDTH     = 412,
  parameter int unsigned MASK_GRAN = 412,
  parameter bit          BYPASS    = 1'b0,
  localparam int unsigned NLANES   = WIDTH / MASK_GRAN,
  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [AW-1:0]     R0_addr,
  input  logic              R0_en,
  output logic [WIDTH-1:0]  R0_data,
  output logic              R0_valid,
  input  logic [AW-1:0]     W0_addr,
  input  logic              W0_en,
  input  logic [NLANES-1:0] W0_mask,
  input  logic [WIDTH-1:0]  W0_data,
  input  logic              flush
);

  localparam logic [AW:0] DEPTH_LIM = DEPTH[AW:0];

  if ((MASK_GRAN == 0) || (WIDTH % MASK_GRAN != 0) || (DEPTH < 1)) begin : g_bad_cfg
    $error("ram_1r1w_mask_sync: WIDTH must be a multiple of MASK_GRAN and DEPTH >= 1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [WIDTH-1:0] r_data_q, r_data_d;
  logic             r_valid_q, r_valid_d;

  logic             w_in_range, r_in_range, w_eff, w_old_valid;
  logic [WIDTH-1:0] w_old_data, w_merged;

  always_comb begin
    w_in_range  = ({1'b0, W0_addr} < DEPTH_LIM);
    r_in_range  = ({1'b0, R0_addr} < DEPTH_LIM);
    w_eff       = W0_en && (|W0_mask) && w_in_range;
    w_old_valid = 1'b0;
    w_old_data  = '0;
    if (w_in_range) begin
      // flush lands before the write, so a flushed entry merges against zero
      w_old_valid = valid_q[W0_addr] && !flush;
      w_old_data  = mem_q[W0_addr];
    end

    w_merged = '0;
    for (int unsigned i = 0; i < NLANES; i++) begin
      if (W0_mask[i])
        w_merged[i*MASK_GRAN +: MASK_GRAN] = W0_data[i*MASK_GRAN +: MASK_GRAN];
      else if (w_old_valid)
        w_merged[i*MASK_GRAN +: MASK_GRAN] = w_old_data[i*MASK_GRAN +: MASK_GRAN];
    end

    valid_d = flush ? '0 : valid_q;
    if (w_eff) valid_d[W0_addr] = 1'b1;

    r_data_d  = r_data_q;
    r_valid_d = r_valid_q;
    if (R0_en) begin
      if (BYPASS && w_eff && (W0_addr == R0_addr)) begin
        r_data_d  = w_merged;
        r_valid_d = 1'b1;
      end else if (r_in_range && valid_q[R0_addr]) begin
        r_data_d  = mem_q[R0_addr];
        r_valid_d = 1'b1;
      end else begin
        r_data_d  = '0;
        r_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= '0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && w_eff) mem_q[W0_addr] <= w_merged;
  end

  assign R0_data  = r_data_q;
  assign R0_valid = r_valid_q;

endmodule

// File: tb/tb_ram_1r1w_mask_sync.sv
// Vector-table bench for ram_1r1w_mask_sync: read-first and write-first instances
// driven in lockstep, expected outputs queued at drive time and checked after the edge.
module tb_ram_1r1w_mask_sync;

  localparam int unsigned DEPTH = 6, WIDTH = 32, MASK_GRAN = 8;
  localparam int unsigned NLANES = 4, AW = 3;

  logic              clock = 1'b0;
  logic              reset, flush, R0_en, W0_en;
  logic [AW-1:0]     R0_addr, W0_addr;
  logic [NLANES-1:0] W0_mask;
  logic [WIDTH-1:0]  W0_data;
  logic [WIDTH-1:0]  r0_data_rf, r0_data_wf;
  logic              r0_valid_rf, r0_valid_wf;

  always #5 clock = ~clock;

  ram_1r1w_mask_sync #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_GRAN(MASK_GRAN), .BYPASS(1'b0)) dut_rf (
    .clock(clock), .reset(reset), .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(r0_data_rf),
    .R0_valid(r0_valid_rf), .W0_addr(W0_addr), .W0_en(W0_en), .W0_mask(W0_mask),
    .W0_data(W0_data), .flush(flush));

  ram_1r1w_mask_sync #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_GRAN(MASK_GRAN), .BYPASS(1'b1)) dut_wf (
    .clock(clock), .reset(reset), .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(r0_data_wf),
    .R0_valid(r0_valid_wf), .W0_addr(W0_addr), .W0_en(W0_en), .W0_mask(W0_mask),
    .W0_data(W0_data), .flush(flush));

  typedef struct {
    string             name;
    logic              rst, fl, we, re;
    logic [AW-1:0]     wa, ra;
    logic [NLANES-1:0] wm;
    logic [WIDTH-1:0]  wd;
    logic [WIDTH-1:0]  e0d, e1d;
    logic              e0v, e1v;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(input string nm, input logic rst, input logic fl,
                              input logic we, input logic [AW-1:0] wa,
                              input logic [NLANES-1:0] wm, input logic [WIDTH-1:0] wd,
                              input logic re, input logic [AW-1:0] ra,
                              input logic [WIDTH-1:0] e0d, input logic e0v,
                              input logic [WIDTH-1:0] e1d, input logic e1v);
    vec_t v;
    v.name = nm; v.rst = rst; v.fl = fl; v.we = we; v.wa = wa; v.wm = wm; v.wd = wd;
    v.re = re; v.ra = ra; v.e0d = e0d; v.e0v = e0v; v.e1d = e1d; v.e1v = e1v;
    return v;
  endfunction

  task automatic check_out();
    vec_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty got=none required=entry");
      return;
    end
    e = sb.pop_front();
    checks += 3;
    if (r0_data_rf !== e.e0d) begin
      failures++;
      $display("FAIL %s rf_data got=%h required=%h", e.name, r0_data_rf, e.e0d);
    end
    if (r0_valid_rf !== e.e0v) begin
      failures++;
      $display("FAIL %s rf_valid got=%b required=%b", e.name, r0_valid_rf, e.e0v);
    end
    if (r0_data_wf !== e.e1d) begin
      failures++;
      $display("FAIL %s wf_data got=%h required=%h", e.name, r0_data_wf, e.e1d);
    end
    if (r0_valid_wf !== e.e1v) begin
      failures++;
      $display("FAIL %s wf_valid got=%b required=%b", e.name, r0_valid_wf, e.e1v);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clock);
    reset = v.rst; flush = v.fl; W0_en = v.we; W0_addr = v.wa; W0_mask = v.wm;
    W0_data = v.wd; R0_en = v.re; R0_addr = v.ra;
    sb.push_back(v);
    @(posedge clock);
    #1;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; W0_en = 1'b0; W0_addr = '0; W0_mask = '0;
    W0_data = '0; R0_en = 1'b0; R0_addr = '0;

    //                 name        rst fl  we  wa    wm       wd            re  ra    rf data/valid       wf data/valid
    vecs.push_back(mk("rst0",      1, 0, 0, 3'd0, 4'h0, 32'h0,        0, 3'd0, 32'h0, 0,        32'h0, 0));
    vecs.push_back(mk("rst1",      1, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd3, 32'h0, 0,        32'h0, 0));
    vecs.push_back(mk("rd3_empty", 0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd3, 32'h0, 0,        32'h0, 0));
    vecs.push_back(mk("rd7_oor",   0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd7, 32'h0, 0,        32'h0, 0));
    vecs.push_back(mk("wr2_m5",    0, 0, 1, 3'd2, 4'h5, 32'hAABBCCDD, 0, 3'd0, 32'h0, 0,        32'h0, 0));
    vecs.push_back(mk("rd2_m5",    0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd2, 32'h00BB00DD, 1, 32'h00BB00DD, 1));
    vecs.push_back(mk("wr2_m8",    0, 0, 1, 3'd2, 4'h8, 32'h11223344, 0, 3'd0, 32'h00BB00DD, 1, 32'h00BB00DD, 1));
    vecs.push_back(mk("rd2_m8",    0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd2, 32'h11BB00DD, 1, 32'h11BB00DD, 1));
    vecs.push_back(mk("byp1_new",  0, 0, 1, 3'd1, 4'hF, 32'hCAFEF00D, 1, 3'd1, 32'h0, 0,        32'hCAFEF00D, 1));
    vecs.push_back(mk("rd1",       0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd1, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1));
    vecs.push_back(mk("byp2_merge",0, 0, 1, 3'd2, 4'h1, 32'h55667788, 1, 3'd2, 32'h11BB00DD, 1, 32'h11BB0088, 1));
    vecs.push_back(mk("rd2_merge", 0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd2, 32'h11BB0088, 1, 32'h11BB0088, 1));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk("fill",    0, 0, 1, 3'(i), 4'hF, 32'(i),      0, 3'd0, 32'h11BB0088, 1, 32'h11BB0088, 1));
    vecs.push_back(mk("rd0_fill",  0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd0, 32'h0, 1,        32'h0, 1));
    vecs.push_back(mk("rd5_fill",  0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd5, 32'h5, 1,        32'h5, 1));
    vecs.push_back(mk("flush_wr4", 0, 1, 1, 3'd4, 4'h1, 32'h99999999, 1, 3'd4, 32'h4, 1,        32'h00000099, 1));
    vecs.push_back(mk("rd0_flush", 0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd0, 32'h0, 0,        32'h0, 0));
    vecs.push_back(mk("rd4_flush", 0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd4, 32'h00000099, 1, 32'h00000099, 1));
    vecs.push_back(mk("wr3_stale", 0, 0, 1, 3'd3, 4'h2, 32'hABCDEF12, 0, 3'd0, 32'h00000099, 1, 32'h00000099, 1));
    vecs.push_back(mk("rd3_stale", 0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd3, 32'h0000EF00, 1, 32'h0000EF00, 1));
    vecs.push_back(mk("wr5",       0, 0, 1, 3'd5, 4'hF, 32'h5,        0, 3'd0, 32'h0000EF00, 1, 32'h0000EF00, 1));
    vecs.push_back(mk("rd5",       0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd5, 32'h5, 1,        32'h5, 1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("hold5",   0, 0, 1, 3'd5, 4'hF, 32'h77777777, 0, 3'd5, 32'h5, 1,       32'h5, 1));
    vecs.push_back(mk("rst_mid",   1, 0, 1, 3'd1, 4'hF, 32'h31313131, 1, 3'd4, 32'h0, 0,       32'h0, 0));
    vecs.push_back(mk("rd5_rst",   0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd5, 32'h0, 0,        32'h0, 0));
    vecs.push_back(mk("rd1_rst",   0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd1, 32'h0, 0,        32'h0, 0));
    vecs.push_back(mk("wr2_full",  0, 0, 1, 3'd2, 4'hF, 32'h12345678, 0, 3'd0, 32'h0, 0,        32'h0, 0));
    vecs.push_back(mk("rd2_full",  0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd2, 32'h12345678, 1, 32'h12345678, 1));
    vecs.push_back(mk("fl_m0_rd2", 0, 1, 1, 3'd0, 4'h0, 32'hFFFFFFFF, 1, 3'd2, 32'h12345678, 1, 32'h12345678, 1));
    vecs.push_back(mk("rd0_m0",    0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd0, 32'h0, 0,        32'h0, 0));
    vecs.push_back(mk("rd2_fl",    0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd2, 32'h0, 0,        32'h0, 0));
    vecs.push_back(mk("wr2_again", 0, 0, 1, 3'd2, 4'hF, 32'h12345678, 0, 3'd0, 32'h0, 0,        32'h0, 0));
    vecs.push_back(mk("rd2_again", 0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd2, 32'h12345678, 1, 32'h12345678, 1));
    vecs.push_back(mk("wr6_oor",   0, 0, 1, 3'd6, 4'hF, 32'hDEADBEEF, 0, 3'd0, 32'h12345678, 1, 32'h12345678, 1));
    vecs.push_back(mk("rd6_oor",   0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd6, 32'h0, 0,        32'h0, 0));
    vecs.push_back(mk("rd2_oor",   0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd2, 32'h12345678, 1, 32'h12345678, 1));
    vecs.push_back(mk("rd0_oor",   0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd0, 32'h0, 0,        32'h0, 0));
    vecs.push_back(mk("byp_m0",    0, 0, 1, 3'd2, 4'h0, 32'hFFFFFFFF, 1, 3'd2, 32'h12345678, 1, 32'h12345678, 1));
    vecs.push_back(mk("byp_oor",   0, 0, 1, 3'd6, 4'hF, 32'hFFFFFFFF, 1, 3'd6, 32'h0, 0,        32'h0, 0));
    vecs.push_back(mk("wr7_rd2",   0, 0, 1, 3'd7, 4'hF, 32'hFFFFFFFF, 1, 3'd2, 32'h12345678, 1, 32'h12345678, 1));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Different-address write and read in the same cycle must not interact.
    apply(mk("ind_wr3",   0, 0, 1, 3'd3, 4'hF, 32'hA5A5A5A5, 0, 3'd0, 32'h12345678, 1, 32'h12345678, 1));
    apply(mk("ind_wr4r3", 0, 0, 1, 3'd4, 4'hF, 32'h5A5A5A5A, 1, 3'd3, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 1));
    apply(mk("ind_rd4",   0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd4, 32'h5A5A5A5A, 1, 32'h5A5A5A5A, 1));

    // Flush with a same-address write: read-first sees old entry, write-first sees flush-zeroed merge.
    apply(mk("fl_byp3",   0, 1, 1, 3'd3, 4'h4, 32'h00C30000, 1, 3'd3, 32'hA5A5A5A5, 1, 32'h00C30000, 1));
    apply(mk("fl_rd3",    0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd3, 32'h00C30000, 1, 32'h00C30000, 1));
    apply(mk("fl_rd4",    0, 0, 0, 3'd0, 4'h0, 32'h0,        1, 3'd4, 32'h0, 0,        32'h0, 0));

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
